// File: rtl/operand_fetch.sv
// Decode-to-execute operand stage: drives regfile reads, forwards EX results,
// stalls on load-use hazards and registers operands into a valid/ready stage.
module operand_fetch #(
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_pc,
  input  logic [4:0]             in_rs1,
  input  logic                   in_rs1_en,
  input  logic [4:0]             in_rs2,
  input  logic                   in_rs2_en,
  input  logic [4:0]             in_rd,
  input  logic                   in_rd_en,
  input  logic                   in_is_load,
  input  logic [31:0]            in_imm,
  output logic                   re1,
  output logic [4:0]             raddr1,
  input  logic [31:0]            rdata1,
  output logic                   re2,
  output logic [4:0]             raddr2,
  input  logic [31:0]            rdata2,
  input  logic                   ex_wen,
  input  logic [4:0]             ex_waddr,
  input  logic [31:0]            ex_wdata,
  input  logic                   ex_is_load,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_imm,
  output logic [31:0]            out_op1,
  output logic [31:0]            out_op2,
  output logic [4:0]             out_rd,
  output logic                   out_rd_en,
  output logic                   out_is_load,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic        hazard;
  logic        accept;
  logic [31:0] op1;
  logic [31:0] op2;

  // Addresses follow the decoded instruction even while stalled.
  assign re1    = in_valid & in_rs1_en;
  assign raddr1 = in_rs1;
  assign re2    = in_valid & in_rs2_en;
  assign raddr2 = in_rs2;

  function automatic logic [31:0] resolve(input logic [4:0]  rs,
                                          input logic        en,
                                          input logic [31:0] rdata);
    if (!en || rs == 5'd0)
      return 32'd0;
    else if (ex_wen && !ex_is_load && ex_waddr == rs)
      return ex_wdata;
    else
      return rdata;
  endfunction

  assign op1 = resolve(in_rs1, in_rs1_en, rdata1);
  assign op2 = resolve(in_rs2, in_rs2_en, rdata2);

  // A load in EX has no data yet, so a dependent consumer must wait a cycle.
  assign hazard = in_valid & ex_wen & ex_is_load & (ex_waddr != 5'd0) &
                  ((in_rs1_en & (in_rs1 == ex_waddr)) |
                   (in_rs2_en & (in_rs2 == ex_waddr)));

  assign in_ready = rst & ~flush & ~hazard & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_imm     <= '0;
      out_op1     <= '0;
      out_op2     <= '0;
      out_rd      <= '0;
      out_rd_en   <= 1'b0;
      out_is_load <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      if (accept) begin
        out_valid   <= 1'b1;
        out_pc      <= in_pc;
        out_imm     <= in_imm;
        out_op1     <= op1;
        out_op2     <= op2;
        out_rd      <= in_rd;
        out_rd_en   <= in_rd_en;
        out_is_load <= in_is_load;
      end else if (out_ready || flush) begin
        out_valid <= 1'b0;
      end

      if (hazard && !flush && stall_cnt != {STALL_CNT_W{1'b1}})
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch; a second instance with a 2-bit counter
// shares the stimulus to exercise stall counter saturation.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid;
  logic [31:0] in_pc, in_imm, rdata1, rdata2, ex_wdata;
  logic [4:0]  in_rs1, in_rs2, in_rd, ex_waddr;
  logic        in_rs1_en, in_rs2_en, in_rd_en, in_is_load;
  logic        ex_wen, ex_is_load, out_ready;

  logic        in_ready, re1, re2, out_valid, out_rd_en, out_is_load;
  logic [4:0]  raddr1, raddr2, out_rd;
  logic [31:0] out_pc, out_imm, out_op1, out_op2;
  logic [15:0] stall_cnt;

  logic        s_in_ready, s_re1, s_re2, s_out_valid, s_out_rd_en, s_out_is_load;
  logic [4:0]  s_raddr1, s_raddr2, s_out_rd;
  logic [31:0] s_out_pc, s_out_imm, s_out_op1, s_out_op2;
  logic [1:0]  s_stall_cnt;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  operand_fetch #(.STALL_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs1_en(in_rs1_en), .in_rs2(in_rs2),
    .in_rs2_en(in_rs2_en), .in_rd(in_rd), .in_rd_en(in_rd_en), .in_is_load(in_is_load),
    .in_imm(in_imm), .re1(re1), .raddr1(raddr1), .rdata1(rdata1), .re2(re2),
    .raddr2(raddr2), .rdata2(rdata2), .ex_wen(ex_wen), .ex_waddr(ex_waddr),
    .ex_wdata(ex_wdata), .ex_is_load(ex_is_load), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_imm(out_imm), .out_op1(out_op1),
    .out_op2(out_op2), .out_rd(out_rd), .out_rd_en(out_rd_en),
    .out_is_load(out_is_load), .stall_cnt(stall_cnt)
  );

  operand_fetch #(.STALL_CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs1_en(in_rs1_en), .in_rs2(in_rs2),
    .in_rs2_en(in_rs2_en), .in_rd(in_rd), .in_rd_en(in_rd_en), .in_is_load(in_is_load),
    .in_imm(in_imm), .re1(s_re1), .raddr1(s_raddr1), .rdata1(rdata1), .re2(s_re2),
    .raddr2(s_raddr2), .rdata2(rdata2), .ex_wen(ex_wen), .ex_waddr(ex_waddr),
    .ex_wdata(ex_wdata), .ex_is_load(ex_is_load), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_pc(s_out_pc), .out_imm(s_out_imm), .out_op1(s_out_op1),
    .out_op2(s_out_op2), .out_rd(s_out_rd), .out_rd_en(s_out_rd_en),
    .out_is_load(s_out_is_load), .stall_cnt(s_stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [31:0] pc, input logic [4:0] rs1, input logic rs1_en,
                        input logic [4:0] rs2, input logic rs2_en, input logic [31:0] imm);
    in_valid  = 1'b1;
    in_pc     = pc;
    in_rs1    = rs1;
    in_rs1_en = rs1_en;
    in_rs2    = rs2;
    in_rs2_en = rs2_en;
    in_imm    = imm;
  endtask

  task automatic set_ex(input logic wen, input logic [4:0] waddr, input logic [31:0] wdata,
                        input logic is_load);
    ex_wen     = wen;
    ex_waddr   = waddr;
    ex_wdata   = wdata;
    ex_is_load = is_load;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_pc = '0; in_imm = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    in_rs1_en = 1'b0; in_rs2_en = 1'b0; in_rd_en = 1'b0; in_is_load = 1'b0;
    rdata1 = '0; rdata2 = '0;
    set_ex(1'b0, 5'd0, 32'd0, 1'b0);

    // Reset held for two cycles.
    step(); step();
    check("rst_out_valid", out_valid, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_in_ready",  in_ready, 0);
    check("rst_out_pc",    out_pc, 0);

    // Plain issue.
    rst = 1'b1;
    set_in(32'h100, 5'd3, 1'b1, 5'd4, 1'b1, 32'h5);
    in_rd = 5'd7; in_rd_en = 1'b1; in_is_load = 1'b1;
    rdata1 = 32'h11; rdata2 = 32'h22;
    #1;
    check("plain_in_ready", in_ready, 1);
    check("plain_re1",      re1, 1);
    check("plain_raddr1",   raddr1, 3);
    check("plain_raddr2",   raddr2, 4);
    step();
    check("plain_out_valid", out_valid, 1);
    check("plain_op1",       out_op1, 32'h11);
    check("plain_op2",       out_op2, 32'h22);
    check("plain_pc",        out_pc, 32'h100);
    check("plain_imm",       out_imm, 32'h5);
    check("plain_rd",        out_rd, 7);
    check("plain_ctl",       {out_rd_en, out_is_load}, 2'b11);

    // EX forwarding on rs1.
    in_is_load = 1'b0;
    set_in(32'h104, 5'd3, 1'b1, 5'd4, 1'b1, 32'h6);
    set_ex(1'b1, 5'd3, 32'hDEAD, 1'b0);
    step();
    check("fwd_op1", out_op1, 32'hDEAD);
    check("fwd_op2", out_op2, 32'h22);

    // Index 0 with an EX write to 0, and a disabled source.
    set_in(32'h108, 5'd0, 1'b1, 5'd4, 1'b0, 32'h7);
    set_ex(1'b1, 5'd0, 32'hBEEF, 1'b0);
    #1;
    check("x0_re2", re2, 0);
    step();
    check("x0_op1",  out_op1, 0);
    check("dis_op2", out_op2, 0);

    // Load-use on rs2.
    set_in(32'h10C, 5'd3, 1'b1, 5'd5, 1'b1, 32'h8);
    set_ex(1'b1, 5'd5, 32'h0, 1'b1);
    rdata2 = 32'h55;
    #1;
    check("lu_in_ready", in_ready, 0);
    check("lu_raddr2",   raddr2, 5);
    step();
    check("lu_out_valid", out_valid, 0);
    check("lu_stall_cnt", stall_cnt, 1);
    set_ex(1'b0, 5'd5, 32'h0, 1'b1);
    #1;
    check("lu_release_ready", in_ready, 1);
    step();
    check("lu_out_valid2", out_valid, 1);
    check("lu_op2",        out_op2, 32'h55);
    check("lu_pc",         out_pc, 32'h10C);
    check("lu_stall_hold", stall_cnt, 1);

    // Backpressure: hold 0x10C while a new instruction waits.
    out_ready = 1'b0;
    set_in(32'h200, 5'd3, 1'b1, 5'd4, 1'b1, 32'h9);
    rdata1 = 32'h33;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_ready", in_ready, 0);
      step();
      check("bp_out_valid", out_valid, 1);
      check("bp_pc",        out_pc, 32'h10C);
      check("bp_op2",       out_op2, 32'h55);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1);
    step();
    check("bp_new_pc",  out_pc, 32'h200);
    check("bp_new_op1", out_op1, 32'h33);

    // Flush with a held instruction and a valid input.
    flush = 1'b1; out_ready = 1'b0;
    set_in(32'h300, 5'd3, 1'b1, 5'd4, 1'b1, 32'hA);
    #1;
    check("fl_in_ready", in_ready, 0);
    step();
    check("fl_out_valid", out_valid, 0);
    check("fl_pc_kept",   out_pc, 32'h200);

    // Hazard together with flush: no count.
    set_ex(1'b1, 5'd3, 32'h0, 1'b1);
    step();
    check("flhz_stall_cnt", stall_cnt, 1);
    check("flhz_out_valid", out_valid, 0);
    flush = 1'b0;

    // Load to x0 never stalls.
    set_in(32'h400, 5'd0, 1'b1, 5'd0, 1'b1, 32'hB);
    set_ex(1'b1, 5'd0, 32'h0, 1'b1);
    #1;
    check("x0ld_in_ready", in_ready, 1);
    step();
    check("x0ld_out_pc",     out_pc, 32'h400);
    check("x0ld_stall_cnt",  stall_cnt, 1);

    // Hazard while backpressured still counts.
    set_in(32'h500, 5'd6, 1'b1, 5'd0, 1'b0, 32'hC);
    set_ex(1'b1, 5'd6, 32'h0, 1'b1);
    step();
    check("bphz_stall_cnt", stall_cnt, 2);
    check("bphz_out_valid", out_valid, 1);
    check("bphz_pc",        out_pc, 32'h400);
    check("bphz_sat_cnt",   s_stall_cnt, 2);

    // Five more hazard cycles: wide counter reaches 7, 2-bit counter sticks at 3.
    for (int i = 0; i < 5; i++) step();
    check("sat_wide_cnt", stall_cnt, 7);
    check("sat_narrow_cnt", s_stall_cnt, 3);

    // Reset mid-backpressure discards the held instruction.
    rst = 1'b0;
    #1;
    check("rst2_in_ready", in_ready, 0);
    step();
    check("rst2_out_valid", out_valid, 0);
    check("rst2_out_pc",    out_pc, 0);
    check("rst2_stall_cnt", stall_cnt, 0);
    check("rst2_sat_cnt",   s_stall_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
